// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaled counter, edge or
// center aligned, with shadowed period/duty/mode applied at period boundaries.
//
// Ports:
//   rst_n      async active-low reset
//   clk_i      clock
//   enable_i   run when high; halts and zeroes outputs when low
//   presc_i    counter advances every presc_i+1 clocks
//   period_i   top count, captured on load_i
//   duty_i     per-channel duty, channel k at [k*WIDTH +: WIDTH]
//   mode_i     0 = edge aligned, 1 = center aligned
//   load_i     strobe capturing period/duty/mode into pending registers
//   pwm_o      registered PWM outputs
//   cycle_o    one-clock pulse after each period boundary
//   pending_o  captured values waiting for the next boundary
module pwm_multi #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                      rst_n,
    input  logic                      clk_i,
    input  logic                      enable_i,
    input  logic [PRESC_WIDTH-1:0]    presc_i,
    input  logic [WIDTH-1:0]          period_i,
    input  logic [CHANNELS*WIDTH-1:0] duty_i,
    input  logic                      mode_i,
    input  logic                      load_i,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic                      cycle_o,
    output logic                      pending_o
);

    logic [PRESC_WIDTH-1:0]    r_presc;
    logic [WIDTH-1:0]          r_cnt;
    logic                      r_dir;
    logic [WIDTH-1:0]          r_per_act;
    logic [CHANNELS*WIDTH-1:0] r_duty_act;
    logic                      r_mode_act;
    logic [WIDTH-1:0]          r_per_pnd;
    logic [CHANNELS*WIDTH-1:0] r_duty_pnd;
    logic                      r_mode_pnd;
    logic                      r_pending;
    logic [CHANNELS-1:0]       r_pwm;
    logic                      r_cycle;

    logic                      w_tick;
    logic [WIDTH-1:0]          w_cnt_nxt;
    logic                      w_dir_nxt;
    logic                      w_bnd;
    logic                      w_take_new;
    logic                      w_take_pend;
    logic                      w_pend_nxt;
    logic [CHANNELS-1:0]       w_cmp;

    // ">=" so a presc_i lowered below the running count ticks at once
    assign w_tick = enable_i && (r_presc >= presc_i);

    // Counter step taken on a tick; dir 0 = up, 1 = down
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (!r_mode_act) begin
            if (r_cnt >= r_per_act)
                w_cnt_nxt = '0;
            else
                w_cnt_nxt = r_cnt + WIDTH'(1);
        end else if (r_per_act == '0) begin
            w_cnt_nxt = '0;
        end else if (!r_dir) begin
            if (r_cnt >= r_per_act) begin
                w_cnt_nxt = r_per_act - WIDTH'(1);
                w_dir_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + WIDTH'(1);
            end
        end else begin
            w_cnt_nxt = r_cnt - WIDTH'(1);
        end
        // Arriving at 0 always resumes counting up
        if (w_cnt_nxt == '0)
            w_dir_nxt = 1'b0;
    end

    // Every return to 0 is a period boundary in both modes
    assign w_bnd       = w_tick && (w_cnt_nxt == '0);
    assign w_take_new  = w_bnd && load_i;
    assign w_take_pend = r_pending && (w_bnd || !enable_i) && !w_take_new;
    assign w_pend_nxt  = load_i ? !w_bnd
                                : (r_pending && enable_i && !w_bnd);

    always_comb begin
        w_cmp = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_cmp[k] = r_cnt < r_duty_act[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_cnt      <= '0;
            r_dir      <= 1'b0;
            r_per_act  <= '0;
            r_duty_act <= '0;
            r_mode_act <= 1'b0;
            r_per_pnd  <= '0;
            r_duty_pnd <= '0;
            r_mode_pnd <= 1'b0;
            r_pending  <= 1'b0;
            r_pwm      <= '0;
            r_cycle    <= 1'b0;
        end else begin
            r_cycle <= w_bnd;
            r_pwm   <= enable_i ? w_cmp : '0;

            if (!enable_i) begin
                r_presc <= '0;
                r_cnt   <= '0;
                r_dir   <= 1'b0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_cnt   <= w_cnt_nxt;
                r_dir   <= w_dir_nxt;
            end else begin
                r_presc <= r_presc + PRESC_WIDTH'(1);
            end

            if (w_take_new) begin
                r_per_act  <= period_i;
                r_duty_act <= duty_i;
                r_mode_act <= mode_i;
            end else if (w_take_pend) begin
                r_per_act  <= r_per_pnd;
                r_duty_act <= r_duty_pnd;
                r_mode_act <= r_mode_pnd;
            end

            if (load_i && !w_bnd) begin
                r_per_pnd  <= period_i;
                r_duty_pnd <= duty_i;
                r_mode_pnd <= mode_i;
            end

            r_pending <= w_pend_nxt;
        end
    end

    assign pwm_o     = r_pwm;
    assign cycle_o   = r_cycle;
    assign pending_o = r_pending;

endmodule

// File: tb/tb_pwm_multi.sv
// Randomized self-checking bench for pwm_multi against a phase-based
// reference model of the PWM period.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  presc;
    logic [7:0]  period;
    logic [31:0] duty;
    logic        mode;
    logic        load;
    logic [3:0]  pwm;
    logic        cyc;
    logic        pend;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: position within the period, not a counter
    int m_pre, m_ph;
    int a_per, a_mode;
    int a_duty [4];
    int p_per, p_mode;
    int p_duty [4];
    int p_flag;
    int e_pwm, e_cyc;

    int hi [4];
    int ncyc;

    pwm_multi #(.WIDTH(8), .CHANNELS(4), .PRESC_WIDTH(8)) dut (
        .rst_n     (rst_n),
        .clk_i     (clk),
        .enable_i  (en),
        .presc_i   (presc),
        .period_i  (period),
        .duty_i    (duty),
        .mode_i    (mode),
        .load_i    (load),
        .pwm_o     (pwm),
        .cycle_o   (cyc),
        .pending_o (pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int plen(input int p, input int md);
        if (md == 0) return p + 1;
        return (p == 0) ? 1 : 2 * p;
    endfunction

    // Counter value at a given position of the period
    function automatic int cval(input int ph, input int p, input int md);
        if (md == 0 || ph <= p) return ph;
        return 2 * p - ph;
    endfunction

    // High clocks per period for one channel, by direct enumeration
    function automatic int ref_highs(input int p, input int md, input int d);
        int s = 0;
        for (int j = 0; j < plen(p, md); j++)
            if (cval(j, p, md) < d) s++;
        return s;
    endfunction

    task automatic mreset();
        m_pre = 0; m_ph = 0;
        a_per = 0; a_mode = 0;
        p_per = 0; p_mode = 0; p_flag = 0;
        for (int k = 0; k < 4; k++) begin
            a_duty[k] = 0;
            p_duty[k] = 0;
        end
        e_pwm = 0; e_cyc = 0;
    endtask

    task automatic step();
        int npwm, bnd, len, cv;
        npwm = 0; bnd = 0;
        len = plen(a_per, a_mode);
        cv = cval(m_ph, a_per, a_mode);
        for (int k = 0; k < 4; k++)
            if (en && cv < a_duty[k]) npwm |= (1 << k);
        if (!en) begin
            m_pre = 0; m_ph = 0;
        end else if (m_pre >= int'(presc)) begin
            m_pre = 0;
            m_ph = (m_ph + 1) % len;
            bnd = (m_ph == 0);
        end else begin
            m_pre++;
        end
        if (bnd && load) begin
            a_per = period; a_mode = mode;
            for (int k = 0; k < 4; k++) a_duty[k] = duty[k*8 +: 8];
            p_flag = 0;
        end else begin
            if (p_flag && (bnd || !en)) begin
                a_per = p_per; a_mode = p_mode;
                for (int k = 0; k < 4; k++) a_duty[k] = p_duty[k];
                p_flag = 0;
            end
            if (load) begin
                p_per = period; p_mode = mode;
                for (int k = 0; k < 4; k++) p_duty[k] = duty[k*8 +: 8];
                p_flag = 1;
            end
        end
        if (!rst_n) mreset();
        else begin
            e_pwm = npwm;
            e_cyc = bnd;
        end
        @(posedge clk);
        #1;
        chk("pwm", int'(pwm), e_pwm);
        chk("cycle", int'(cyc), e_cyc);
        chk("pending", int'(pend), p_flag);
        for (int k = 0; k < 4; k++) hi[k] += int'(pwm[k]);
        ncyc += int'(cyc);
    endtask

    task automatic clr_win();
        for (int k = 0; k < 4; k++) hi[k] = 0;
        ncyc = 0;
    endtask

    task automatic do_load(input int p, input int md,
                           input int d0, input int d1);
        period = 8'(p);
        mode = md[0];
        duty = {8'd0, 8'd0, 8'(d1), 8'(d0)};
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Runs until a boundary pulse is seen; bounded so the bench cannot hang
    task automatic to_bnd(input string tag);
        int n = 0;
        while (!cyc && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        mreset();
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_cycle", int'(cyc), 0);
        chk("rst_pending", int'(pend), 0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; presc = '0; period = '0;
        duty = '0; mode = 1'b0; load = 1'b0;
        mreset();
        clr_win();
        #12;
        chk("rst_pwm0", int'(pwm), 0);
        chk("rst_pend0", int'(pend), 0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (20) step();

        // Edge mode, period 9, duty0 3
        do_load(9, 0, 3, 0);
        to_bnd("edge");
        clr_win();
        repeat (10) step();
        chk("edge_hi0", hi[0], ref_highs(9, 0, 3));
        chk("edge_ncyc", ncyc, 1);

        // Center mode, period 4, duty1 2
        do_load(4, 1, 0, 2);
        to_bnd("ctr");
        clr_win();
        repeat (8) step();
        chk("ctr_hi1", hi[1], ref_highs(4, 1, 2));
        chk("ctr_ncyc", ncyc, 1);

        // Duty limits over 100 periods
        do_load(9, 0, 0, 255);
        to_bnd("lim");
        clr_win();
        repeat (1000) step();
        chk("lim_hi0", hi[0], 0);
        chk("lim_hi1", hi[1], 1000);
        chk("lim_ncyc", ncyc, 100);

        // Mid-period loads: only the second applies at the boundary
        to_bnd("mid");
        step(); step();
        do_load(9, 0, 5, 255);
        chk("mid_pend", int'(pend), 1);
        step();
        do_load(9, 0, 7, 255);
        to_bnd("mid2");
        clr_win();
        repeat (10) step();
        chk("mid_hi0", hi[0], ref_highs(9, 0, 7));

        // Prescaler 3 with enable toggled mid-period
        presc = 8'd3;
        repeat (17) step();
        en = 1'b0;
        repeat (5) step();
        chk("dis_pwm", int'(pwm), 0);
        en = 1'b1;
        clr_win();
        repeat (40) step();
        chk("presc_ncyc", ncyc, 1);

        // Reset with pending set, outputs stay low until a new load
        presc = 8'd0;
        to_bnd("rst");
        step(); step();
        do_load(9, 0, 2, 3);
        chk("pre_rst_pend", int'(pend), 1);
        async_reset();
        clr_win();
        repeat (50) step();
        chk("post_rst_hi0", hi[0], 0);
        chk("post_rst_hi1", hi[1], 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            load = 1'b0;
            if ($urandom_range(0, 24) == 0) begin
                load = 1'b1;
                period = 8'($urandom_range(0, 12));
                mode = 1'($urandom_range(0, 1));
                duty = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                        8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
            end
            if ($urandom_range(0, 59) == 0) presc = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) en = ~en;
            step();
            if (i == 1500) begin
                load = 1'b0;
                async_reset();
            end
        end
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
